move_history_ctrl: RTL and testbench
====================================

# move_history_ctrl

Sequencer that owns the single read/write port of the 64×4-bit board store and applies or reverts moves on it. Every applied move is pushed onto an internal LIFO as a {start, end, captured} record; an undo request pops the top record and restores both squares. It sits between the move generator/search logic (requesters) and the board memory, and replaces ad-hoc combinational board rewrites with a serialized, handshaked read-modify-write sequence.

## Interface
- DEPTH, 64, history entries; power of two, ≥2
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- make_valid  in  1  request to apply a move
- make_start  in  6  source square index 0–63
- make_end  in  6  destination square index 0–63
- make_ready  out  1  make request accepted when make_valid && make_ready
- undo_valid  in  1  request to revert the most recent move
- undo_ready  out  1  undo request accepted when undo_valid && undo_ready
- board_addr  out  6  board port address
- board_re  out  1  read enable; board_rdata valid the following cycle
- board_rdata  in  4  board read data (registered, 1-cycle latency)
- board_we  out  1  write enable
- board_wdata  out  4  write data
- depth  out  $clog2(DEPTH)+1  records currently stored
- empty  out  1  depth == 0
- full  out  1  depth == DEPTH
- top_start, top_end  out  6 each  record at top of stack (0 when empty)
- top_captured  out  4  captured piece of top record (0 when empty)
- done  out  1  one-cycle pulse on completion of a make or undo
- err_overflow  out  1  one-cycle pulse: make_valid while idle and full
- err_underflow  out  1  one-cycle pulse: undo_valid while idle and empty

## Operation
- Piece code 4'h0 = empty square.
- States: IDLE, MK_RD_S, MK_RD_E, MK_WR_E, MK_WR_S, UN_RD_E, UN_WR_S, UN_WR_E.
- make_ready = IDLE && !full. undo_ready = IDLE && !empty && !make_valid (make has priority on a simultaneous request).
- Make (accept in IDLE → MK_RD_S): latch start/end at accept.
  - MK_RD_S: addr=start, re=1.
  - MK_RD_E: addr=end, re=1; latch moving = rdata.
  - MK_WR_E: latch captured = rdata; addr=end, we=1, wdata=moving.
  - MK_WR_S: addr=start, we=1, wdata=0; write {start,end,captured} at stack[depth]; depth+1 → IDLE.
- Undo (accept in IDLE → UN_RD_E): latch top record and decrement depth at accept.
  - UN_RD_E: addr=end, re=1.
  - UN_WR_S: addr=start, we=1, wdata=rdata.
  - UN_WR_E: addr=end, we=1, wdata=captured → IDLE.
- start == end is not checked; the sequence runs as specified (net result: square cleared, record pushed).
- err_overflow / err_underflow: no state change, no board access, request not accepted; the pulse repeats each cycle the condition holds. Both are suppressed while not IDLE.
- board_re and board_we are never high in the same cycle; both are 0 in IDLE.

## Timing
- Reset (rst_n low at a clk edge): state IDLE, depth 0, empty 1, full 0, board_re/board_we/board_addr/board_wdata 0, done/err_* 0, top_* 0. Reset may occur mid-sequence; the board is left as partially written and the stack is cleared.
- Make accepted at edge T: board accesses occur in cycles T+1..T+4. done=1 and depth incremented in T+5 (IDLE, ready again in the same cycle). Latency is 5 cycles; throughput is one make per 5 cycles.
- Undo accepted at edge T: depth decrements from cycle T+1. Accesses occur in T+1..T+3, done=1 in T+4. Latency is 4 cycles.
- top_* are combinational from stack[depth-1] and reflect the updated depth.
- Requests arriving while not IDLE are ignored, not queued; the requester holds valid until ready.

## Test plan
- Reset: drive rst_n=0 for 2 cycles, then 1 → depth=0, empty=1, make_ready=1, undo_ready=0, no we/re for 3 idle cycles.
- Capture and undo: board[12]=4'h1, board[28]=4'h9; make 12→28 → writes (28,4'h1) then (12,0), done at T+5, top={12,28,4'h9}. Undo → writes (12,4'h1) then (28,4'h9), done at T+4, empty=1.
- Underflow: undo_valid=1 on empty for 3 cycles → err_underflow high 3 cycles, board_we never asserted, depth stays 0.
- Overflow/LIFO order: DEPTH makes with distinct squares → full=1, the next make gives err_overflow and no access. DEPTH undos restore the records in reverse order, ending with depth=0.
- Simultaneous: depth=1, make_valid and undo_valid both high in IDLE → make accepted, undo_ready=0, depth=2 after done.
- Reset mid-make: assert rst_n=0 in the MK_WR_E cycle → next cycle is IDLE, depth=0, board_we=0, no done pulse.

Source files
------------

// File: rtl/move_history_ctrl.sv
// Serialized make/undo sequencer for the 64x4 board store, with a LIFO of
// {start, end, captured} records so every applied move can be reverted.
module move_history_ctrl #(
  parameter int DEPTH = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      make_valid,
  input  logic [5:0]                make_start,
  input  logic [5:0]                make_end,
  output logic                      make_ready,
  input  logic                      undo_valid,
  output logic                      undo_ready,
  output logic [5:0]                board_addr,
  output logic                      board_re,
  input  logic [3:0]                board_rdata,
  output logic                      board_we,
  output logic [3:0]                board_wdata,
  output logic [$clog2(DEPTH):0]    depth,
  output logic                      empty,
  output logic                      full,
  output logic [5:0]                top_start,
  output logic [5:0]                top_end,
  output logic [3:0]                top_captured,
  output logic                      done,
  output logic                      err_overflow,
  output logic                      err_underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int DW = PW + 1;

  typedef enum logic [2:0] {
    IDLE, MK_RD_S, MK_RD_E, MK_WR_E, MK_WR_S, UN_RD_E, UN_WR_S, UN_WR_E
  } state_t;

  state_t      state;
  logic [5:0]  start_q;
  logic [5:0]  end_q;
  logic [3:0]  moving_q;
  logic [3:0]  captured_q;
  logic [15:0] stack_mem [DEPTH];
  logic [15:0] top_rec;
  logic [DW-1:0] depth_m1;
  logic        make_fire;
  logic        undo_fire;

  assign empty      = (depth == '0);
  assign full       = (depth == DW'(DEPTH));
  assign make_ready = (state == IDLE) && !full;
  assign undo_ready = (state == IDLE) && !empty && !make_valid;
  assign make_fire  = make_valid && make_ready;
  assign undo_fire  = undo_valid && undo_ready;

  assign err_overflow  = (state == IDLE) && make_valid && full;
  assign err_underflow = (state == IDLE) && undo_valid && empty;

  assign depth_m1     = depth - DW'(1);
  assign top_rec      = stack_mem[depth_m1[PW-1:0]];
  assign top_start    = empty ? 6'd0 : top_rec[15:10];
  assign top_end      = empty ? 6'd0 : top_rec[9:4];
  assign top_captured = empty ? 4'd0 : top_rec[3:0];

  // Undo restores the start square from the read issued one cycle earlier,
  // so that write data comes straight off the read port.
  always_comb begin
    board_wdata = 4'd0;
    case (state)
      MK_WR_E: board_wdata = moving_q;
      UN_WR_S: board_wdata = board_rdata;
      UN_WR_E: board_wdata = captured_q;
      default: board_wdata = 4'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      depth      <= '0;
      board_re   <= 1'b0;
      board_we   <= 1'b0;
      board_addr <= 6'd0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (make_fire) begin
            board_addr <= make_start;
            board_re   <= 1'b1;
            state      <= MK_RD_S;
          end else if (undo_fire) begin
            depth      <= depth_m1;
            board_addr <= top_end;
            board_re   <= 1'b1;
            state      <= UN_RD_E;
          end
        end
        MK_RD_S: begin
          board_addr <= end_q;
          state      <= MK_RD_E;
        end
        MK_RD_E: begin
          board_re <= 1'b0;
          board_we <= 1'b1;
          state    <= MK_WR_E;
        end
        MK_WR_E: begin
          board_addr <= start_q;
          state      <= MK_WR_S;
        end
        MK_WR_S: begin
          board_we <= 1'b0;
          depth    <= depth + DW'(1);
          done     <= 1'b1;
          state    <= IDLE;
        end
        UN_RD_E: begin
          board_re   <= 1'b0;
          board_we   <= 1'b1;
          board_addr <= start_q;
          state      <= UN_WR_S;
        end
        UN_WR_S: begin
          board_addr <= end_q;
          state      <= UN_WR_E;
        end
        UN_WR_E: begin
          board_we <= 1'b0;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath registers and the record store carry no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && make_fire) begin
      start_q <= make_start;
      end_q   <= make_end;
    end else if (state == IDLE && undo_fire) begin
      start_q    <= top_start;
      end_q      <= top_end;
      captured_q <= top_captured;
    end
    if (state == MK_RD_E) moving_q <= board_rdata;
    if (state == MK_WR_E) captured_q <= board_rdata;
    if (state == MK_WR_S) stack_mem[depth[PW-1:0]] <= {start_q, end_q, captured_q};
  end

endmodule

// File: tb/tb_move_history_ctrl.sv
// Bench for move_history_ctrl: board memory, transaction-level reference model
// with a per-cycle compare, and directed scenarios with literal expectations.
module tb_move_history_ctrl;
  localparam int DEPTH = 64;
  localparam int NC    = 4096;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       make_valid = 1'b0;
  logic [5:0] make_start = 6'd0;
  logic [5:0] make_end = 6'd0;
  logic       make_ready;
  logic       undo_valid = 1'b0;
  logic       undo_ready;
  logic [5:0] board_addr;
  logic       board_re;
  logic [3:0] board_rdata = 4'd0;
  logic       board_we;
  logic [3:0] board_wdata;
  logic [6:0] depth;
  logic       empty, full, done, err_overflow, err_underflow;
  logic [5:0] top_start, top_end;
  logic [3:0] top_captured;

  always #5 clk = ~clk;

  move_history_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .make_valid(make_valid), .make_start(make_start), .make_end(make_end),
    .make_ready(make_ready),
    .undo_valid(undo_valid), .undo_ready(undo_ready),
    .board_addr(board_addr), .board_re(board_re), .board_rdata(board_rdata),
    .board_we(board_we), .board_wdata(board_wdata),
    .depth(depth), .empty(empty), .full(full),
    .top_start(top_start), .top_end(top_end), .top_captured(top_captured),
    .done(done), .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  // Board store: registered read, one-cycle latency.
  logic [3:0] mem [64];
  logic [3:0] init_img [64];
  always @(posedge clk) begin
    if (board_we) mem[board_addr] <= board_wdata;
    if (board_re) board_rdata <= mem[board_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0d expected=%0d", nm, $time, act, exp);
    end
  endtask

  // Reference model: expected board contents, record stack and bus schedule.
  int          gold [64];
  bit          e_re [NC];
  bit          e_we [NC];
  bit          e_done [NC];
  int          e_addr [NC];
  int          e_wd [NC];
  logic [15:0] q [$];
  bit          pend_v = 1'b0;
  int          pend_cyc = 0;
  logic [15:0] pend_rec;
  int          busy_until = 0;
  int          cyc = 0;
  bit          armed = 1'b0;

  always @(negedge clk) begin
    int k, s, e;
    bit idle;
    logic [15:0] rec;
    k = cyc;
    if (k + 8 >= NC) begin
      $display("FAIL cycle_budget cycles=%0d limit=%0d", k, NC - 8);
      $fatal(1);
    end
    idle = (k >= busy_until);
    if (armed) begin
      if (pend_v && pend_cyc == k) begin
        q.push_back(pend_rec);
        pend_v = 1'b0;
      end
      chk("depth", int'(depth), q.size());
      chk("empty", int'(empty), int'(q.size() == 0));
      chk("full", int'(full), int'(q.size() == DEPTH));
      rec = (q.size() > 0) ? q[$] : 16'd0;
      chk("top_start", int'(top_start), int'(rec[15:10]));
      chk("top_end", int'(top_end), int'(rec[9:4]));
      chk("top_captured", int'(top_captured), int'(rec[3:0]));
      chk("board_re", int'(board_re), int'(e_re[k]));
      chk("board_we", int'(board_we), int'(e_we[k]));
      chk("done", int'(done), int'(e_done[k]));
      if (e_re[k] || e_we[k]) chk("board_addr", int'(board_addr), e_addr[k]);
      if (e_we[k]) begin
        chk("board_wdata", int'(board_wdata), e_wd[k]);
        gold[e_addr[k]] = e_wd[k];
      end
      chk("make_ready", int'(make_ready), int'(idle && q.size() < DEPTH));
      chk("undo_ready", int'(undo_ready), int'(idle && q.size() > 0 && !make_valid));
      chk("err_overflow", int'(err_overflow), int'(idle && make_valid && q.size() == DEPTH));
      chk("err_underflow", int'(err_underflow), int'(idle && undo_valid && q.size() == 0));
    end
    if (!rst_n) begin
      armed = 1'b1;
      q.delete();
      pend_v = 1'b0;
      busy_until = k + 1;
      for (int j = k + 1; j <= k + 8; j++) begin
        e_re[j] = 1'b0; e_we[j] = 1'b0; e_done[j] = 1'b0;
      end
    end else if (armed && idle) begin
      if (make_valid && q.size() < DEPTH) begin
        s = int'(make_start);
        e = int'(make_end);
        e_re[k+1] = 1'b1; e_addr[k+1] = s;
        e_re[k+2] = 1'b1; e_addr[k+2] = e;
        e_we[k+3] = 1'b1; e_addr[k+3] = e; e_wd[k+3] = gold[s];
        e_we[k+4] = 1'b1; e_addr[k+4] = s; e_wd[k+4] = 0;
        e_done[k+5] = 1'b1;
        pend_v = 1'b1; pend_cyc = k + 5;
        pend_rec = {6'(s), 6'(e), 4'(gold[e])};
        busy_until = k + 5;
      end else if (undo_valid && q.size() > 0) begin
        rec = q.pop_back();
        s = int'(rec[15:10]);
        e = int'(rec[9:4]);
        e_re[k+1] = 1'b1; e_addr[k+1] = e;
        e_we[k+2] = 1'b1; e_addr[k+2] = s; e_wd[k+2] = gold[e];
        e_we[k+3] = 1'b1; e_addr[k+3] = e; e_wd[k+3] = int'(rec[3:0]);
        e_done[k+4] = 1'b1;
        busy_until = k + 4;
      end
    end
    cyc = k + 1;
  end

  task automatic do_make(input int s, input int e, input int exp_lat);
    int n;
    bit acc;
    @(posedge clk); #1;
    make_start = 6'(s);
    make_end   = 6'(e);
    make_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (make_ready) acc = 1'b1;
    end
    chk("make_accept", int'(acc), 1);
    @(posedge clk); #1 make_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    chk("make_latency", n, exp_lat);
  endtask

  task automatic do_undo(input int exp_lat);
    int n;
    bit acc;
    @(posedge clk); #1 undo_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (undo_ready) acc = 1'b1;
    end
    chk("undo_accept", int'(acc), 1);
    @(posedge clk); #1 undo_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    chk("undo_latency", n, exp_lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t limit reached", $time);
    $fatal(1);
  end

  initial begin
    int cnt, bad, n;
    for (int i = 0; i < 64; i++) init_img[i] = 4'((i * 7) & 15);
    init_img[12] = 4'h1;
    init_img[28] = 4'h9;
    for (int i = 0; i < 64; i++) begin
      mem[i]  = init_img[i];
      gold[i] = int'(init_img[i]);
    end

    // Reset for two edges, then three idle cycles.
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_depth", int'(depth), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_make_ready", int'(make_ready), 1);
    chk("rst_undo_ready", int'(undo_ready), 0);
    chk("rst_addr", int'(board_addr), 0);
    chk("rst_wdata", int'(board_wdata), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_top_start", int'(top_start), 0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("rst_idle_re", int'(board_re), 0);
      chk("rst_idle_we", int'(board_we), 0);
    end

    // Capture and undo.
    do_make(12, 28, 5);
    chk("cap_mem28", int'(mem[28]), 1);
    chk("cap_mem12", int'(mem[12]), 0);
    chk("cap_top_start", int'(top_start), 12);
    chk("cap_top_end", int'(top_end), 28);
    chk("cap_top_captured", int'(top_captured), 9);
    chk("cap_depth", int'(depth), 1);
    do_undo(4);
    chk("undo_mem12", int'(mem[12]), 1);
    chk("undo_mem28", int'(mem[28]), 9);
    chk("undo_empty", int'(empty), 1);

    // Underflow held for three cycles.
    @(posedge clk); #1 undo_valid = 1'b1;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (err_underflow) cnt++;
    end
    @(posedge clk); #1 undo_valid = 1'b0;
    chk("underflow_pulses", cnt, 3);
    chk("underflow_depth", int'(depth), 0);

    // Fill the stack, provoke overflow, then unwind in LIFO order.
    for (int i = 0; i < DEPTH; i++) do_make(i, (i + 17) % 64, 5);
    chk("fill_full", int'(full), 1);
    chk("fill_depth", int'(depth), 64);
    @(posedge clk); #1;
    make_start = 6'd0;
    make_end   = 6'd1;
    make_valid = 1'b1;
    cnt = 0;
    bad = 0;
    repeat (2) begin
      @(negedge clk);
      if (err_overflow) cnt++;
    end
    @(posedge clk); #1 make_valid = 1'b0;
    @(negedge clk);
    if (board_re || board_we) bad++;
    chk("overflow_pulses", cnt, 2);
    chk("overflow_no_access", bad, 0);
    for (int i = 0; i < DEPTH; i++) do_undo(4);
    chk("unwind_depth", int'(depth), 0);
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== init_img[i]) bad++;
    chk("board_restore", bad, 0);

    // Simultaneous make and undo with one record stored.
    do_make(5, 6, 5);
    @(posedge clk); #1;
    make_start = 6'd7;
    make_end   = 6'd8;
    make_valid = 1'b1;
    undo_valid = 1'b1;
    @(negedge clk);
    chk("sim_undo_ready", int'(undo_ready), 0);
    chk("sim_make_ready", int'(make_ready), 1);
    @(posedge clk); #1;
    make_valid = 1'b0;
    undo_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    chk("sim_latency", n, 5);
    chk("sim_depth", int'(depth), 2);
    chk("sim_top_start", int'(top_start), 7);

    // Reset asserted during the MK_WR_E cycle of a make.
    @(posedge clk); #1;
    make_start = 6'd20;
    make_end   = 6'd21;
    make_valid = 1'b1;
    @(negedge clk);
    chk("mid_accept", int'(make_ready), 1);
    @(posedge clk); #1 make_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_we_before_rst", int'(board_we), 1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_depth", int'(depth), 0);
    chk("mid_we", int'(board_we), 0);
    chk("mid_done", int'(done), 0);
    chk("mid_make_ready", int'(make_ready), 1);
    chk("mid_mem21", int'(mem[21]), 12);
    chk("mid_mem20", int'(mem[20]), 12);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("mid_no_done", cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
